spi_chan_seq: RTL and testbench

SPI_CHAN_SEQ -- requirements
Module: spi_chan_seq

---
 rtl/spi_chan_seq.sv | 172 +++++++++++++++++
 tb/tb_spi_chan_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_chan_seq.sv
// Multi-channel SPI transaction sequencer: round-robin arbitration of N_CH clients
// onto one mode-0 SPI bus with per-channel chip selects and a shared D/C line.
module spi_chan_seq #(
    parameter int N_CH      = 3,
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 4,
    parameter int CS_GAP    = 2,
    localparam int LW       = $clog2(MAX_BYTES + 1)
) (
    input  logic                       sys_clk_pin,
    input  logic                       rst_pin,
    input  logic [N_CH-1:0]            req,
    input  logic [N_CH*LW-1:0]         tx_cnt,
    input  logic [N_CH*LW-1:0]         rx_cnt,
    input  logic [N_CH*MAX_BYTES*8-1:0] tx_data,
    input  logic [N_CH-1:0]            dc_in,
    output logic [N_CH-1:0]            grant,
    output logic [N_CH-1:0]            done,
    output logic [MAX_BYTES*8-1:0]     rx_data,
    output logic                       busy,
    output logic                       spi_sck,
    output logic                       spi_mosi,
    input  logic                       spi_miso,
    output logic [N_CH-1:0]            spi_cs_n,
    output logic                       spi_dc
);

    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW   = MAX_BYTES * 8;
    localparam int BW   = $clog2(DW + 1);
    localparam int HALF = CLK_DIV / 2;
    localparam int CMAX = (CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV;
    localparam int NW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ptr_q, win_c;
    logic [N_CH-1:0] rot_c;
    logic            any_req;
    int              pos_c;
    int              t_c, r_c;
    logic            zero_c;
    logic [DW-1:0]   tx_sel_c;
    logic            dc_sel_c;

    logic [NW-1:0]   cnt_q;
    logic [BW-1:0]   bit_q, tx_bits_q, tot_bits_q, rx_pos;
    logic [DW-1:0]   tx_sr_q;
    logic            dc_q;
    logic [N_CH-1:0] grant_q, done_q;
    logic [DW-1:0]   rx_data_q;
    logic            gap_last, div_last, div_half, cs_act;

    // Rotating the request vector by the pointer turns round-robin into first-set-bit.
    assign rot_c = N_CH'({req, req} >> ptr_q);

    always_comb begin
        any_req = 1'b0;
        win_c   = '0;
        pos_c   = 0;
        for (int i = 0; i < N_CH; i++) begin
            pos_c = int'(ptr_q) + i;
            if (pos_c >= N_CH) pos_c = pos_c - N_CH;
            if (!any_req && rot_c[i]) begin
                any_req = 1'b1;
                win_c   = CW'(pos_c);
            end
        end
    end

    // Winner's counts (saturated) and payload, byte 0 placed at the top for MSB-first shifting.
    always_comb begin
        t_c      = 0;
        r_c      = 0;
        tx_sel_c = '0;
        dc_sel_c = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_c == CW'(i)) begin
                t_c      = int'(tx_cnt[i*LW +: LW]);
                r_c      = int'(rx_cnt[i*LW +: LW]);
                dc_sel_c = dc_in[i];
                for (int k = 0; k < MAX_BYTES; k++)
                    tx_sel_c[(MAX_BYTES-1-k)*8 +: 8] = tx_data[(i*MAX_BYTES+k)*8 +: 8];
            end
        end
        if (t_c > MAX_BYTES) t_c = MAX_BYTES;
        if (r_c > MAX_BYTES - t_c) r_c = MAX_BYTES - t_c;
        zero_c = (t_c + r_c) == 0;
    end

    assign gap_last = cnt_q == NW'(CS_GAP - 1);
    assign div_last = cnt_q == NW'(CLK_DIV - 1);
    assign div_half = cnt_q == NW'(HALF - 1);
    assign rx_pos   = bit_q - tx_bits_q;

    always_ff @(posedge sys_clk_pin or posedge rst_pin) begin
        if (rst_pin) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = zero_c ? GAP : SETUP;
            SETUP:   if (gap_last) state_d = SHIFT;
            SHIFT:   if (div_last && bit_q == tot_bits_q) state_d = HOLD;
            HOLD:    if (gap_last) state_d = GAP;
            GAP:     if (gap_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_pin or posedge rst_pin) begin
        if (rst_pin) begin
            cnt_q      <= '0;
            ptr_q      <= '0;
            bit_q      <= '0;
            tx_bits_q  <= '0;
            tot_bits_q <= '0;
            tx_sr_q    <= '0;
            dc_q       <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            rx_data_q  <= '0;
        end else begin
            done_q <= '0;
            if (state_q == IDLE || state_d != state_q || (state_q == SHIFT && div_last))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE: if (any_req) begin
                    grant_q    <= N_CH'(1) << win_c;
                    ptr_q      <= (win_c == CW'(N_CH - 1)) ? '0 : win_c + 1'b1;
                    tx_sr_q    <= tx_sel_c;
                    dc_q       <= dc_sel_c;
                    tx_bits_q  <= BW'(8 * t_c);
                    tot_bits_q <= BW'(8 * (t_c + r_c));
                    bit_q      <= '0;
                    rx_data_q  <= '0;
                    if (zero_c) done_q <= N_CH'(1) << win_c;
                end
                SHIFT: begin
                    // MISO is taken on the first high cycle; only rx-phase bits are kept.
                    if (cnt_q == NW'(0) && bit_q >= tx_bits_q) begin
                        for (int k = 0; k < DW; k++)
                            if (rx_pos == BW'(k)) rx_data_q[k ^ 7] <= spi_miso;
                    end
                    if (div_half) begin
                        bit_q   <= bit_q + 1'b1;
                        tx_sr_q <= tx_sr_q << 1;
                    end
                end
                HOLD: if (gap_last) done_q <= grant_q;
                GAP:  if (done_q != '0) grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign cs_act   = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign busy     = state_q != IDLE;
    assign grant    = grant_q;
    assign done     = done_q;
    assign rx_data  = rx_data_q;
    assign spi_cs_n = cs_act ? ~grant_q : '1;
    assign spi_sck  = (state_q == SHIFT) && (cnt_q < NW'(HALF));
    assign spi_dc   = cs_act && dc_q;
    assign spi_mosi = (state_q == SETUP || state_q == SHIFT) && (bit_q < tx_bits_q) && tx_sr_q[DW-1];

endmodule

// File: tb/tb_spi_chan_seq.sv
// Self-checking bench for spi_chan_seq: directed vector table, round-robin and reset
// sequences, then randomized transactions against a spec-level reference model.
module tb_spi_chan_seq;

    localparam int N_CH      = 3;
    localparam int MAX_BYTES = 4;
    localparam int CLK_DIV   = 4;
    localparam int CS_GAP    = 2;
    localparam int LW        = $clog2(MAX_BYTES + 1);
    localparam int DW        = MAX_BYTES * 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_CH-1:0]      req;
    logic [N_CH*LW-1:0]   tx_cnt, rx_cnt;
    logic [N_CH*DW-1:0]   tx_data;
    logic [N_CH-1:0]      dc_in;
    logic [N_CH-1:0]      grant, done;
    logic [DW-1:0]        rx_data;
    logic                 busy, spi_sck, spi_mosi, spi_miso, spi_dc;
    logic [N_CH-1:0]      spi_cs_n;

    int n_chk = 0;
    int n_err = 0;

    spi_chan_seq #(.N_CH(N_CH), .MAX_BYTES(MAX_BYTES), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .sys_clk_pin(clk), .rst_pin(rst), .req(req), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
        .tx_data(tx_data), .dc_in(dc_in), .grant(grant), .done(done), .rx_data(rx_data),
        .busy(busy), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .spi_dc(spi_dc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            ch;
        int            tx;
        int            rx;
        logic [DW-1:0] data;
        logic          dc;
        logic [DW-1:0] sb;
        int            et;
        int            er;
        logic [DW-1:0] exp_rx;
        int            exp_len;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        chk({tag, "_cs_n"},  64'(spi_cs_n), 64'({N_CH{1'b1}}));
        chk({tag, "_sck"},   64'(spi_sck), 64'(0));
        chk({tag, "_mosi"},  64'(spi_mosi), 64'(0));
        chk({tag, "_dc"},    64'(spi_dc), 64'(0));
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_done"},  64'(done), 64'(0));
        chk({tag, "_busy"},  64'(busy), 64'(0));
        chk({tag, "_rx"},    64'(rx_data), 64'(0));
    endtask

    // Slave stream: junk ones during the tx phase, then the reply bytes MSB first.
    function automatic logic miso_bit(input int j, input int et, input logic [DW-1:0] sb);
        int jj;
        jj = j - 8 * et;
        if (j < 8 * et) return 1'b1;
        if (jj >= DW) return 1'b0;
        return sb[(jj / 8) * 8 + 7 - (jj % 8)];
    endfunction

    task automatic model_eff(input int tx, input int rx, output int et, output int er);
        et = (tx > MAX_BYTES) ? MAX_BYTES : tx;
        er = (rx > MAX_BYTES) ? MAX_BYTES : rx;
        if (et + er > MAX_BYTES) er = MAX_BYTES - et;
    endtask

    task automatic run_txn(input string nm, input int ch, input int tx, input int rx,
                           input logic [DW-1:0] data, input logic dc, input logic [DW-1:0] sb,
                           input int et, input int er, input logic [DW-1:0] exp_rx, input int exp_len);
        logic [63:0]   mo_got, mo_exp;
        logic [DW-1:0] rx_at_done;
        int            pulses, falls, c0, len;
        bit            acc, fin, prev_sck, cs_bad, dc_bad;
        mo_got = '0; mo_exp = '0; rx_at_done = '0;
        pulses = 0; falls = 0; c0 = 0; len = -1;
        acc = 0; fin = 0; prev_sck = 0; cs_bad = 0; dc_bad = 0;
        @(negedge clk);
        tx_cnt[ch*LW +: LW]  = LW'(tx);
        rx_cnt[ch*LW +: LW]  = LW'(rx);
        tx_data[ch*DW +: DW] = data;
        dc_in[ch]            = dc;
        spi_miso             = 1'b0;
        req[ch]              = 1'b1;
        for (int k = 0; k < 4000 && !fin; k++) begin
            @(negedge clk);
            if (!acc && grant[ch]) begin
                acc = 1; c0 = k;
                // Inputs are latched at acceptance: disturb them all from here on.
                req[ch] = 1'b0;
                tx_data[ch*DW +: DW] = ~data;
                dc_in[ch] = ~dc;
                tx_cnt[ch*LW +: LW] = '0;
                rx_cnt[ch*LW +: LW] = LW'(3);
            end
            if (acc) begin
                if (spi_sck && !prev_sck) begin
                    pulses++;
                    mo_got = {mo_got[62:0], spi_mosi};
                end
                if (!spi_sck && prev_sck) falls++;
                spi_miso = miso_bit(falls, et, sb);
                if (!$onehot0(~spi_cs_n)) cs_bad = 1;
                if (spi_cs_n != '1 && spi_cs_n[ch]) cs_bad = 1;
                if (spi_cs_n == '1 && spi_sck) cs_bad = 1;
                if (!spi_cs_n[ch] && spi_dc !== dc) dc_bad = 1;
                if (spi_cs_n == '1 && spi_dc) dc_bad = 1;
                if (done[ch]) begin
                    fin = 1; len = k - c0; rx_at_done = rx_data;
                end
            end
            prev_sck = spi_sck;
        end
        req[ch] = 1'b0;
        for (int b = 0; b < 8 * (et + er); b++)
            mo_exp = {mo_exp[62:0], (b < 8 * et) ? data[(b / 8) * 8 + 7 - (b % 8)] : 1'b0};
        chk({nm, "_done_seen"}, 64'(fin), 64'(1));
        chk({nm, "_len"},       64'(len), 64'(exp_len));
        chk({nm, "_pulses"},    64'(pulses), 64'(8 * (et + er)));
        chk({nm, "_mosi"},      mo_got, mo_exp);
        chk({nm, "_rx_data"},   64'(rx_at_done), 64'(exp_rx));
        chk({nm, "_cs"},        64'(cs_bad), 64'(0));
        chk({nm, "_dc"},        64'(dc_bad), 64'(0));
        @(negedge clk);
        chk({nm, "_done_once"}, 64'(done[ch]), 64'(0));
        chk({nm, "_grant_clr"}, 64'(grant), 64'(0));
    endtask

    task automatic rr_seq(input string nm, input logic [N_CH-1:0] mask, input int n,
                          input int o0, input int o1, input int o2);
        int              order[8];
        int              exp_o[3];
        int              no, hi_run, min_gap;
        bit              seen, fin;
        logic [N_CH-1:0] pg;
        no = 0; hi_run = 0; min_gap = 1000; seen = 0; fin = 0; pg = '0;
        exp_o[0] = o0; exp_o[1] = o1; exp_o[2] = o2;
        for (int i = 0; i < 8; i++) order[i] = -1;
        @(negedge clk);
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i]) begin
                tx_cnt[i*LW +: LW]  = LW'(1);
                rx_cnt[i*LW +: LW]  = '0;
                tx_data[i*DW +: DW] = DW'(8'h30 + i);
                dc_in[i]            = 1'b0;
            end
        end
        req = mask;
        for (int k = 0; k < 3000 && !fin; k++) begin
            @(negedge clk);
            if (grant != '0 && pg == '0) begin
                for (int i = 0; i < N_CH; i++)
                    if (grant[i] && no < 8) begin order[no] = i; no++; end
            end
            pg = grant;
            if (spi_cs_n == '1) hi_run++;
            else begin
                if (seen && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0; seen = 1;
            end
            req = req & ~done;
            if (req == '0 && !busy) fin = 1;
        end
        req = '0;
        chk({nm, "_finished"}, 64'(fin), 64'(1));
        chk({nm, "_count"},    64'(no), 64'(n));
        for (int i = 0; i < n && i < 3; i++)
            chk($sformatf("%s_order%0d", nm, i), 64'(order[i]), 64'(exp_o[i]));
        chk({nm, "_gap_ok"}, 64'(min_gap >= CS_GAP), 64'(1));
    endtask

    initial begin
        int            pulses, et, er, ch, tx, rx, exp_len;
        bit            prev, done_seen;
        logic [DW-1:0] data, sb, erx;
        logic          dc;

        rst = 1'b1; req = '0; tx_cnt = '0; rx_cnt = '0; tx_data = '0; dc_in = '0; spi_miso = 1'b0;

        //            ch tx rx data          dc    miso bytes      et er exp_rx          len
        vecs[0] = '{0, 1, 2, 32'h0000_000C, 1'b0, 32'h0000_0381, 1, 2, 32'h0000_0381, 100};
        vecs[1] = '{2, 4, 0, 32'h004F_014E, 1'b1, 32'hDEAD_BEEF, 4, 0, 32'h0000_0000, 132};
        vecs[2] = '{1, 0, 0, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 0, 0, 32'h0000_0000, 0};
        vecs[3] = '{0, 6, 1, 32'hA1B2_C3D4, 1'b0, 32'h5555_5555, 4, 0, 32'h0000_0000, 132};
        vecs[4] = '{1, 0, 3, 32'h0000_0000, 1'b1, 32'h77FF_5AA5, 0, 3, 32'h00FF_5AA5, 100};
        vecs[5] = '{2, 2, 5, 32'h0000_9966, 1'b0, 32'h1234_C3E7, 2, 2, 32'h0000_C3E7, 132};

        repeat (3) @(negedge clk);
        check_idle_outs("in_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outs("idle");

        rr_seq("rr_all", 3'b111, 3, 0, 1, 2);
        rr_seq("rr_wrap", 3'b011, 2, 0, 1, 0);

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].tx, vecs[i].rx, vecs[i].data,
                    vecs[i].dc, vecs[i].sb, vecs[i].et, vecs[i].er, vecs[i].exp_rx, vecs[i].exp_len);

        // Reset in the middle of a 3-byte shift.
        @(negedge clk);
        tx_cnt[0 +: LW] = LW'(3); rx_cnt[0 +: LW] = '0; tx_data[0 +: DW] = 32'h00A5_C33C;
        dc_in[0] = 1'b1; req[0] = 1'b1;
        pulses = 0; prev = 0; done_seen = 0;
        for (int k = 0; k < 2000 && pulses < 10; k++) begin
            @(negedge clk);
            if (spi_sck && !prev) pulses++;
            prev = spi_sck;
            if (done[0]) done_seen = 1;
        end
        chk("rst_mid_pulses", 64'(pulses), 64'(10));
        chk("rst_mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check_idle_outs("rst_mid");
        req = '0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0) done_seen = 1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != '0 || busy) done_seen = 1;
        end
        chk("rst_mid_no_done", 64'(done_seen), 64'(0));
        run_txn("post_rst", 2, 1, 1, 32'h0000_00F0, 1'b0, 32'h0000_003C, 1, 1, 32'h0000_003C, 68);

        for (int it = 0; it < 24; it++) begin
            ch   = $urandom_range(0, N_CH - 1);
            tx   = $urandom_range(0, 7);
            rx   = $urandom_range(0, 7);
            data = DW'($urandom);
            sb   = DW'($urandom);
            dc   = 1'($urandom_range(0, 1));
            model_eff(tx, rx, et, er);
            erx = '0;
            for (int k = 0; k < er; k++) erx[k*8 +: 8] = sb[k*8 +: 8];
            exp_len = (et + er == 0) ? 0 : 2 * CS_GAP + 8 * (et + er) * CLK_DIV;
            run_txn($sformatf("rnd%0d", it), ch, tx, rx, data, dc, sb, et, er, erx, exp_len);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err + 1, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
